// File: rtl/adder_pkg.sv
// Shared encodings for the bit-serial adder controller.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder cell, purely combinational.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Classic sum/majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused for
// WIDTH cycles, LSB first, with start/busy handshake and a done pulse.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb_in;
  logic             fa_s;
  logic             fa_co;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // FSM, operand shift registers, bit counter and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // The DONE cycle doubles as an accept slot so a held start
        // sustains one operation every WIDTH+1 cycles.
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= (sub == OP_SUB) ? ~b : b;
            carry <= (sub == OP_ADD) ? cin : 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_co;
          if (cnt == CNT_MSB) begin
            c_msb_in <= fa_co;
          end
          if (cnt == CNT_LAST) begin
            sum   <= {fa_s, s_sh[WIDTH-1:1]};
            cout  <= fa_co;
            ovf   <= c_msb_in ^ fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
